// File: rtl/hachure_gpio.sv
// hachure_gpio: Wishbone-slave GPIO block for the programmable bidir pads.
// Holds per-pin output, output-enable and pad-configuration registers,
// synchronises the pad inputs, and raises a level interrupt on enabled edges.
module hachure_gpio #(
   parameter int NGPIO       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [3:0]       wb_adr_i,
   input  logic [31:0]      wb_dat_i,
   input  logic [3:0]       wb_sel_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack_o,
   input  logic [NGPIO-1:0] gpi_i,
   output logic [NGPIO-1:0] gpo_o,
   output logic [NGPIO-1:0] gpeo_o,
   output logic [NGPIO-1:0] gpcs_o,
   output logic [NGPIO-1:0] gpsl_o,
   output logic [NGPIO-1:0] gppu_o,
   output logic [NGPIO-1:0] gppd_o,
   output logic             irq_o
);

   localparam logic [3:0] ADR_IN      = 4'h0;
   localparam logic [3:0] ADR_OUT     = 4'h1;
   localparam logic [3:0] ADR_OE      = 4'h2;
   localparam logic [3:0] ADR_CS      = 4'h3;
   localparam logic [3:0] ADR_SL      = 4'h4;
   localparam logic [3:0] ADR_PU      = 4'h5;
   localparam logic [3:0] ADR_PD      = 4'h6;
   localparam logic [3:0] ADR_OUT_SET = 4'h7;
   localparam logic [3:0] ADR_OUT_CLR = 4'h8;
   localparam logic [3:0] ADR_RISE_EN = 4'h9;
   localparam logic [3:0] ADR_FALL_EN = 4'hA;
   localparam logic [3:0] ADR_PEND    = 4'hB;

   logic [NGPIO-1:0] out_q, out_d, oe_q, oe_d, cs_q, cs_d, sl_q, sl_d;
   logic [NGPIO-1:0] pu_q, pu_d, pd_q, pd_d;
   logic [NGPIO-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [NGPIO-1:0] pend_q, pend_d, prev_q, prev_d;
   logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_q, sync_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;

   logic             access, wr;
   logic [NGPIO-1:0] wdata, in_w, pend_set, pend_clr, rdata;
   logic             unused_bits;

   // Upper data lanes and byte selects never reach a register (NGPIO <= 8).
   assign unused_bits = ^{wb_dat_i[31:NGPIO], wb_sel_i[3:1]};

   assign in_w = sync_q[SYNC_STAGES-1];

   // Bus decode, register next-state, edge detection and read mux.
   always_comb begin
      out_d     = out_q;
      oe_d      = oe_q;
      cs_d      = cs_q;
      sl_d      = sl_q;
      pu_d      = pu_q;
      pd_d      = pd_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      pend_clr  = '0;
      rdata     = '0;
      dat_d     = '0;

      // A new access is accepted only while ack is low, so ack pulses at most every other cycle.
      access = wb_cyc_i & wb_stb_i & ~ack_q;
      wr     = access & wb_we_i & wb_sel_i[0];
      wdata  = wb_dat_i[NGPIO-1:0];
      ack_d  = access;

      // Input path: shift the pads through the synchroniser; prev trails IN by one cycle.
      sync_d = {sync_q[SYNC_STAGES-2:0], gpi_i};
      prev_d = in_w;

      // Edge events use the enables as they stood before this edge, so enable writes are never retroactive.
      pend_set = (in_w & ~prev_q & rise_en_q) | (~in_w & prev_q & fall_en_q);

      if (wr) begin
         case (wb_adr_i)
            ADR_OUT:     out_d     = wdata;
            ADR_OE:      oe_d      = wdata;
            ADR_CS:      cs_d      = wdata;
            ADR_SL:      sl_d      = wdata;
            ADR_PU:      pu_d      = wdata;
            ADR_PD:      pd_d      = wdata;
            ADR_OUT_SET: out_d     = out_q | wdata;
            ADR_OUT_CLR: out_d     = out_q & ~wdata;
            ADR_RISE_EN: rise_en_d = wdata;
            ADR_FALL_EN: fall_en_d = wdata;
            ADR_PEND:    pend_clr  = wdata;
            default:     ;
         endcase
      end

      // Set after clear: a new event on the same edge as a W1C keeps the bit.
      pend_d = (pend_q & ~pend_clr) | pend_set;

      case (wb_adr_i)
         ADR_IN:      rdata = in_w;
         ADR_OUT:     rdata = out_q;
         ADR_OE:      rdata = oe_q;
         ADR_CS:      rdata = cs_q;
         ADR_SL:      rdata = sl_q;
         ADR_PU:      rdata = pu_q;
         ADR_PD:      rdata = pd_q;
         ADR_RISE_EN: rdata = rise_en_q;
         ADR_FALL_EN: rdata = fall_en_q;
         ADR_PEND:    rdata = pend_q;
         default:     rdata = '0;
      endcase

      if (access && !wb_we_i) begin
         dat_d = 32'(rdata);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         out_q     <= '0;
         oe_q      <= '0;
         cs_q      <= '0;
         sl_q      <= '1;
         pu_q      <= '0;
         pd_q      <= '1;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         prev_q    <= '0;
         sync_q    <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         out_q     <= out_d;
         oe_q      <= oe_d;
         cs_q      <= cs_d;
         sl_q      <= sl_d;
         pu_q      <= pu_d;
         pd_q      <= pd_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         prev_q    <= prev_d;
         sync_q    <= sync_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   assign gpo_o    = out_q;
   assign gpeo_o   = oe_q;
   assign gpcs_o   = cs_q;
   assign gpsl_o   = sl_q;
   assign gppu_o   = pu_q;
   assign gppd_o   = pd_q;
   assign irq_o    = |pend_q;
   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;

endmodule
